prefix_adder_pipe: RTL

//  Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor.

---
 rtl/prefix_adder_pipe.sv | 125 ++++++++++++
 1 files changed

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready stream interface.
// Registers: operand stage, one stage per LEVELS_PER_STAGE prefix levels, then the result stage.

module ks_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);
  assign g_out = g_hi | (p_hi & g_lo);
  assign p_out = p_hi & p_lo;
endmodule

module prefix_adder_pipe #(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int L  = $clog2(WIDTH);
  localparam int NS = (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] x;
    logic             c0;
  } stage_t;

  logic [NS+1:0]    vld_pipe;
  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   carry;

  // Whole pipe moves or holds as one; bubbles are never squeezed out.
  assign advance   = !vld_pipe[NS+1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[NS+1];
  assign b_eff     = sub ? ~b : b;

  always_ff @(posedge clk) begin
    if (rst)          vld_pipe <= '0;
    else if (advance) vld_pipe <= {vld_pipe[NS:0], in_valid};
  end

  for (genvar s = 0; s <= NS; s++) begin : g_stg
    stage_t q;
    if (s == 0) begin : g_in
      always_ff @(posedge clk) begin
        if (advance) begin
          q.g  <= a & b_eff;
          q.p  <= a | b_eff;
          q.x  <= a ^ b_eff;
          q.c0 <= sub | cin;
        end
      end
    end else begin : g_reg
      localparam int LAST = ((s * LEVELS_PER_STAGE < L) ? s * LEVELS_PER_STAGE : L) - 1;
      always_ff @(posedge clk) begin
        if (advance) begin
          q.g  <= g_lvl[LAST].go;
          q.p  <= g_lvl[LAST].po;
          q.x  <= g_stg[s-1].q.x;
          q.c0 <= g_stg[s-1].q.c0;
        end
      end
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int SPAN = 1 << k;
    logic [WIDTH-1:0] gi, pi, go, po;
    if (k % LEVELS_PER_STAGE == 0) begin : g_from_reg
      assign gi = g_stg[k / LEVELS_PER_STAGE].q.g;
      assign pi = g_stg[k / LEVELS_PER_STAGE].q.p;
    end else begin : g_from_lvl
      assign gi = g_lvl[k-1].go;
      assign pi = g_lvl[k-1].po;
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= SPAN) begin : g_cell
        ks_cell u_cell (
          .g_hi (gi[i]),
          .p_hi (pi[i]),
          .g_lo (gi[i-SPAN]),
          .p_lo (pi[i-SPAN]),
          .g_out(go[i]),
          .p_out(po[i])
        );
      end else begin : g_pass
        assign go[i] = gi[i];
        assign po[i] = pi[i];
      end
    end
  end

  // Group terms span [i:0]; the carry-in enters as G[-1] through the group propagate.
  assign carry = {g_stg[NS].q.g | (g_stg[NS].q.p & {WIDTH{g_stg[NS].q.c0}}), g_stg[NS].q.c0};

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (advance) begin
      sum  <= g_stg[NS].q.x ^ carry[WIDTH-1:0];
      cout <= carry[WIDTH];
      ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end
endmodule
